// File: rtl/context_restore_sequencer_if.sv
// Context restore sequencer bus.
// Groups the switch handshake, the valid-table update inputs (ctx_saved,
// freed), the context store read port and the restore beat stream.
//   master : the environment (requester, writer, memory controller, store).
//   slave  : the sequencer.
interface context_restore_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  switch_req;
    logic [7:0]            switch_thread;
    logic                  switch_ack;
    logic                  switch_miss;
    logic                  ctx_saved;
    logic [7:0]            ctx_saved_thread;
    logic                  freed;
    logic [8:0]            freed_address;
    logic                  rd_en;
    logic [7:0]            rd_thread;
    logic [1:0]            rd_stage;
    logic [3:0]            rd_field;
    logic [31:0]           rd_data;
    logic                  rst_valid;
    logic [1:0]            rst_stage;
    logic [3:0]            rst_field;
    logic [31:0]           rst_data;
    logic [NUM_STAGES-1:0] stage_select;
    logic                  busy;

    modport master (
        output switch_req, switch_thread, ctx_saved, ctx_saved_thread,
               freed, freed_address, rd_data,
        input  switch_ack, switch_miss, rd_en, rd_thread, rd_stage, rd_field,
               rst_valid, rst_stage, rst_field, rst_data, stage_select, busy
    );

    modport slave (
        input  switch_req, switch_thread, ctx_saved, ctx_saved_thread,
               freed, freed_address, rd_data,
        output switch_ack, switch_miss, rd_en, rd_thread, rd_stage, rd_field,
               rst_valid, rst_stage, rst_field, rst_data, stage_select, busy
    );
endinterface

// File: rtl/context_restore_sequencer.sv
// Context restore sequencer.
// On an accepted switch request it walks the thread's saved context
// (NUM_STAGES x FIELDS_PER_STAGE 32-bit fields), streams each word out as a
// restore beat, raises the per-stage restore mux select once a stage's last
// field has gone out, and finishes with a one-cycle switch_ack.
// A per-thread valid table (set by ctx_saved, cleared by freed, freed wins)
// decides hit/miss; freeing the thread being restored aborts the walk.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset.
//   bus        : context_restore_sequencer_if.slave (handshake, table
//                updates, store read port, restore beats, stage_select, busy).
// Optional feature macro CTX_CONSUME_EN: a successful restore clears the
// thread's valid bit in its ack cycle (a same-cycle ctx_saved still wins).
module context_restore_sequencer #(
    parameter int NUM_STAGES       = 4,
    parameter int FIELDS_PER_STAGE = 15,
    parameter int NUM_THREADS      = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    context_restore_sequencer_if.slave   bus
);
    localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGES - 1);
    localparam logic [3:0] LAST_FIELD = 4'(FIELDS_PER_STAGE - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [NUM_THREADS-1:0] valid_q;
    logic [7:0]             thread_q;
    logic [1:0]             stage_q;
    logic [3:0]             field_q;
    logic                   ack_prev_q;
    logic                   miss_ack_q;
    // index 1: read issued last cycle, index 2: beat on the output this cycle
    logic [2:1]             vld_pipe;
    logic [2:1][1:0]        stg_pipe;
    logic [2:1][3:0]        fld_pipe;
    logic [31:0]            rst_data_q;
    logic [NUM_STAGES-1:0]  sel_q;

    logic accept, hit, abort, last_rd, rd_en, ack;

    always_comb begin
        // A pending miss ack also blocks acceptance so a held request is not
        // taken again in the very cycle it is being acknowledged.
        accept  = (state_q == IDLE) && bus.switch_req && !ack_prev_q && !miss_ack_q;
        hit     = valid_q[bus.switch_thread];
        abort   = ((state_q == READ) || (state_q == DRAIN)) && bus.freed &&
                  (bus.freed_address[7:0] == thread_q);
        last_rd = (stage_q == LAST_STAGE) && (field_q == LAST_FIELD);
        rd_en   = (state_q == READ) && !abort;
        ack     = (state_q == DONE) || miss_ack_q;

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && hit) state_d = READ;
            READ:    if (abort) state_d = IDLE;
                     else if (last_rd) state_d = DRAIN;
            // last read is in vld_pipe[1]; once it moves on, its beat is out
            DRAIN:   if (abort) state_d = IDLE;
                     else if (!vld_pipe[1]) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            thread_q   <= '0;
            stage_q    <= '0;
            field_q    <= '0;
            ack_prev_q <= 1'b0;
            miss_ack_q <= 1'b0;
            vld_pipe   <= '0;
            stg_pipe   <= '0;
            fld_pipe   <= '0;
            rst_data_q <= '0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_prev_q <= ack;
            miss_ack_q <= (accept && !hit) || abort;

            if (accept && hit) begin
                thread_q <= bus.switch_thread;
                stage_q  <= '0;
                field_q  <= '0;
            end else if (rd_en) begin
                if (field_q == LAST_FIELD) begin
                    field_q <= '0;
                    stage_q <= stage_q + 2'd1;
                end else begin
                    field_q <= field_q + 4'd1;
                end
            end

            vld_pipe   <= abort ? 2'b00 : {vld_pipe[1], rd_en};
            stg_pipe   <= {stg_pipe[1], stage_q};
            fld_pipe   <= {fld_pipe[1], field_q};
            rst_data_q <= bus.rd_data;

            if (abort || ack)
                sel_q <= '0;
            else if (vld_pipe[2] && (fld_pipe[2] == LAST_FIELD))
                sel_q[stg_pipe[2]] <= 1'b1;

            // Later assignments take priority: consume < ctx_saved < freed.
`ifdef CTX_CONSUME_EN
            if (state_q == DONE)
                valid_q[thread_q] <= 1'b0;
`else
`endif
            if (bus.ctx_saved)
                valid_q[bus.ctx_saved_thread] <= 1'b1;
            if (bus.freed)
                valid_q[bus.freed_address[7:0]] <= 1'b0;
        end
    end

    assign bus.switch_ack   = ack;
    assign bus.switch_miss  = miss_ack_q;
    assign bus.rd_en        = rd_en;
    assign bus.rd_thread    = thread_q;
    assign bus.rd_stage     = stage_q;
    assign bus.rd_field     = field_q;
    assign bus.rst_valid    = vld_pipe[2];
    assign bus.rst_stage    = stg_pipe[2];
    assign bus.rst_field    = fld_pipe[2];
    assign bus.rst_data     = rst_data_q;
    assign bus.stage_select = sel_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_context_restore_sequencer.sv
// Bench for context_restore_sequencer: directed test-plan scenarios followed
// by random traffic, all checked every cycle against a transaction-level
// model (restore start cycle + offset arithmetic, valid table as an array).
module tb_context_restore_sequencer;
    localparam int NF = 15;
    localparam int N  = 4 * NF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    context_restore_sequencer_if #(.NUM_STAGES(4)) bus();
    context_restore_sequencer #(.NUM_STAGES(4), .FIELDS_PER_STAGE(NF), .NUM_THREADS(256))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0, bad = 0, cyc = 0;
    logic [31:0] salt;

    // stimulus values for the next cycle
    logic rst_v, req, sav, frd;
    logic [7:0] sthr, savthr;
    logic [8:0] faddr;

    // store model: previous cycle's read request
    logic p_rd;
    logic [7:0] p_thr;
    int p_stg, p_fld;

    // sampled DUT outputs
    logic o_ack, o_miss, o_rd_en, o_busy, o_rv;
    logic [3:0] o_sel;
    logic [5:0] o_beat;

    // reference model state
    bit vt[256];
    bit m_known = 0, m_active = 0, m_ack_prev = 0;
    int m_t0, m_miss_at = -1, m_k;
    logic [7:0] m_th;

    // expectations for the current cycle
    logic e_rd_en, e_rv, e_busy, e_ack, e_miss, ev_accept, ev_abort, ev_done;
    int e_rs, e_rf, e_bs, e_bf;
    logic [31:0] e_data;
    logic [3:0] e_sel;

    function automatic logic [31:0] word(logic [7:0] t, int s, int f);
        return ({t, t, t, t} * 32'h9E3779B1) ^ (32'(s) << 28) ^ (32'(f) << 20) ^ salt;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void model_eval();
        m_k      = m_active ? cyc - m_t0 : -1;
        ev_abort = m_active && m_k >= 1 && m_k <= N + 2 && frd && faddr[7:0] == m_th;
        ev_done  = m_active && m_k == N + 3;
        e_rd_en  = m_active && m_k >= 1 && m_k <= N && !ev_abort;
        e_rs     = (m_k - 1) / NF;
        e_rf     = (m_k - 1) % NF;
        e_rv     = m_active && m_k >= 3 && m_k <= N + 2;
        e_bs     = (m_k - 3) / NF;
        e_bf     = (m_k - 3) % NF;
        e_data   = word(m_th, e_bs, e_bf);
        e_sel    = 4'b0;
        for (int s = 0; s < 4; s++)
            if (m_active && m_k >= 3 + NF * s + NF) e_sel[s] = 1'b1;
        e_busy   = m_active && m_k >= 1;
        e_miss   = (m_miss_at == cyc);
        e_ack    = ev_done || e_miss;
        ev_accept = !m_active && req && !m_ack_prev && !e_ack;
    endfunction

    function automatic void model_update();
        if (!rst_v) begin
            foreach (vt[i]) vt[i] = 0;
            m_active = 0; m_miss_at = -1; m_ack_prev = 0; m_known = 1;
            return;
        end
        if (ev_accept) begin
            if (vt[sthr]) begin m_active = 1; m_t0 = cyc; m_th = sthr; end
            else m_miss_at = cyc + 1;
        end
        if (ev_abort) begin m_active = 0; m_miss_at = cyc + 1; end
        if (ev_done) begin
            m_active = 0;
`ifdef CTX_CONSUME_EN
            vt[m_th] = 0;
`else
`endif
        end
        if (sav) vt[savthr] = 1;
        if (frd) vt[faddr[7:0]] = 0;
        m_ack_prev = e_ack;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        rst_n                = rst_v;
        bus.switch_req       = req;
        bus.switch_thread    = sthr;
        bus.ctx_saved        = sav;
        bus.ctx_saved_thread = savthr;
        bus.freed            = frd;
        bus.freed_address    = faddr;
        bus.rd_data          = p_rd ? word(p_thr, p_stg, p_fld) : 32'($urandom());
        #1;
        model_eval();
        @(negedge clk);
        o_ack = bus.switch_ack; o_miss = bus.switch_miss; o_rd_en = bus.rd_en;
        o_busy = bus.busy; o_sel = bus.stage_select; o_rv = bus.rst_valid;
        o_beat = {bus.rst_stage, bus.rst_field};
        if (m_known) begin
            chk("rd_en", o_rd_en, e_rd_en);
            if (e_rd_en)
                chk("rd_addr", {bus.rd_thread, bus.rd_stage, bus.rd_field}, {m_th, 2'(e_rs), 4'(e_rf)});
            chk("rst_valid", o_rv, e_rv);
            if (e_rv) begin
                chk("rst_beat", o_beat, {2'(e_bs), 4'(e_bf)});
                chk("rst_data", bus.rst_data, e_data);
            end
            chk("stage_select", o_sel, e_sel);
            chk("busy", o_busy, e_busy);
            chk("switch_ack", o_ack, e_ack);
            if (e_ack) chk("switch_miss", o_miss, e_miss);
        end
        p_rd = (bus.rd_en === 1'b1);
        p_thr = bus.rd_thread; p_stg = int'(bus.rd_stage); p_fld = int'(bus.rd_field);
        model_update();
        cyc++;
    endtask

    task automatic save(input logic [7:0] t);
        sav = 1; savthr = t; cycle();
        sav = 0; cycle();
    endtask

    // raise a request and hold it until ack; reports ack offset from raise
    task automatic req_once(input logic [7:0] t, output int ack_k, output logic miss_o);
        req = 1; sthr = t; ack_k = -1; miss_o = 1'bx;
        for (int k = 0; k < 80; k++) begin
            cycle();
            if (o_ack) begin ack_k = k; miss_o = o_miss; break; end
        end
        req = 0;
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(4))
            0: return 8'h12;
            1: return 8'h33;
            2: return 8'h40;
            3: return 8'h77;
            default: return 8'($urandom());
        endcase
    endfunction

    initial begin
        int n_rd, nb, first, last, ack_k, nack, rd_after, rv_after;
        logic [5:0] fb, lb;
        logic m1;
        bit any_busy, any_rd;
        salt = $urandom();
        rst_n = 1'b0; rst_v = 0; req = 0; sav = 0; frd = 0;
        sthr = 0; savthr = 0; faddr = 0; p_rd = 0;

        repeat (3) cycle();
        rst_v = 1;
        cycle();
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_sel", o_sel, 4'b0);
        chk("reset_ack", o_ack, 1'b0);
        chk("reset_rst_valid", o_rv, 1'b0);

        // full restore of 0x12
        save(8'h12);
        req = 1; sthr = 8'h12; n_rd = 0; nb = 0; first = -1; last = -1; fb = 0; lb = 0;
        for (int k = 0; k <= 64; k++) begin
            cycle();
            if (o_ack) req = 0;
            if (o_rd_en) n_rd++;
            if (o_rv) begin
                if (first < 0) begin first = k; fb = o_beat; end
                last = k; lb = o_beat; nb++;
            end
            if (k == 17) chk("sel_t17", o_sel, 4'b0000);
            if (k == 18) chk("sel_t18", o_sel, 4'b0001);
            if (k == 63) begin
                chk("ack_t63", o_ack, 1'b1);
                chk("miss_t63", o_miss, 1'b0);
                chk("sel_t63", o_sel, 4'b1111);
            end
            if (k == 64) chk("sel_t64", o_sel, 4'b0000);
        end
        chk("rd_count", n_rd, 60);
        chk("beat_count", nb, 60);
        chk("first_beat_cyc", first, 3);
        chk("last_beat_cyc", last, 62);
        chk("first_beat", fb, {2'd0, 4'd0});
        chk("last_beat", lb, {2'd3, 4'd14});

        // never-saved thread misses
        req = 1; sthr = 8'h40; ack_k = -1; any_busy = 0; any_rd = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (o_ack && ack_k < 0) begin ack_k = k; chk("miss_flag_40", o_miss, 1'b1); req = 0; end
            any_busy |= o_busy; any_rd |= o_rd_en;
        end
        chk("miss_ack_cyc", ack_k, 1);
        chk("miss_busy", any_busy, 1'b0);
        chk("miss_rd_en", any_rd, 1'b0);

        // abort by freeing the thread at T+20
        save(8'h12);
        req = 1; sthr = 8'h12; ack_k = -1; rd_after = 0; rv_after = 0; faddr = 9'h012;
        for (int k = 0; k < 27; k++) begin
            frd = (k == 20);
            cycle();
            if (k >= 20 && o_rd_en) rd_after++;
            if (k >= 22 && o_rv) rv_after++;
            if (o_ack && ack_k < 0) begin ack_k = k; chk("abort_miss", o_miss, 1'b1); req = 0; end
        end
        frd = 0;
        chk("abort_ack_cyc", ack_k, 21);
        chk("abort_rd_en", rd_after, 0);
        chk("abort_rst_valid", rv_after, 0);

        // same-cycle save and free of 0x33: free wins
        sav = 1; savthr = 8'h33; frd = 1; faddr = 9'h133; cycle();
        sav = 0; frd = 0; cycle();
        req_once(8'h33, ack_k, m1);
        chk("save_free_ack", ack_k, 1);
        chk("save_free_miss", m1, 1'b1);
        cycle();

        // request held through ack: one ack, re-acceptance at T+65
        save(8'h12);
        req = 1; sthr = 8'h12; nack = 0;
        for (int k = 0; k <= 66; k++) begin
            sav = (k == 63); savthr = 8'h12;
            cycle();
            nack += int'(o_ack);
            if (k == 64) chk("held_busy_t64", o_busy, 1'b0);
            if (k == 65) chk("held_rd_t65", o_rd_en, 1'b0);
            if (k == 66) chk("held_rd_t66", o_rd_en, 1'b1);
        end
        sav = 0; req = 0;
        chk("held_ack_count", nack, 1);
        ack_k = -1;
        for (int k = 0; k < 80; k++) begin
            cycle();
            if (o_ack) begin ack_k = k; chk("held_second_miss", o_miss, 1'b0); break; end
        end
        chk("held_second_ack", ack_k, 61);
        cycle();

        // back-to-back switches to 0x12
        save(8'h12);
        req_once(8'h12, ack_k, m1);
        chk("b2b_first_ack", ack_k, 63);
        chk("b2b_first_miss", m1, 1'b0);
        cycle();
        req_once(8'h12, ack_k, m1);
`ifdef CTX_CONSUME_EN
        chk("b2b_second_ack", ack_k, 1);
        chk("b2b_second_miss", m1, 1'b1);
`else
        chk("b2b_second_ack", ack_k, 63);
        chk("b2b_second_miss", m1, 1'b0);
`endif
        cycle();

        // reset mid-restore: no ack afterwards
        save(8'h12);
        req = 1; sthr = 8'h12;
        repeat (10) cycle();
        rst_v = 0; req = 0;
        repeat (2) cycle();
        rst_v = 1; nack = 0;
        repeat (70) begin cycle(); nack += int'(o_ack); end
        chk("reset_abort_acks", nack, 0);
        chk("reset_abort_busy", o_busy, 1'b0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if (req) begin
                if (o_ack) begin
                    if ($urandom_range(3) != 0) req = 0;
                end else if ($urandom_range(199) == 0) begin
                    req = 0;
                end
            end else if ($urandom_range(3) == 0) begin
                req = 1; sthr = pick();
            end
            sav = ($urandom_range(3) == 0); savthr = pick();
            frd = ($urandom_range(39) == 0); faddr = {1'($urandom_range(1)), pick()};
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
